i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 64 ++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter: derives BCLK/LRCLK from clk and serialises one mono
// sample per frame onto both channels, with the standard one-BCLK data delay.
module i2s_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned WORD_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic signed [WORD_BITS-1:0] in,
    output logic                        tick,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        sdata
);

    localparam int unsigned FRAME_BITS = 2 * WORD_BITS;
    localparam int unsigned SLOT_W     = $clog2(FRAME_BITS);

    logic [7:0]            div;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_W-1:0]     slot_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  div_wrap;
    logic                  fall;

    always_comb begin
        div_wrap = (div == 8'(CLK_DIV - 1));
        fall     = div_wrap & bclk;
        slot_nxt = slot + 1'b1;
    end

    // The MSB of shreg is always the next bit to emit. After 63 shifts it holds
    // bit 0 of the old frame word, which is exactly what slot 0 must carry, so
    // emitting it and reloading on the same edge gives the one-BCLK delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            bclk  <= 1'b1;
            slot  <= '1;
            lrclk <= 1'b1;
            sdata <= 1'b0;
            tick  <= 1'b0;
            shreg <= '0;
        end else begin
            tick <= fall && (slot == '1);
            div  <= div_wrap ? '0 : div + 8'd1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
            if (fall) begin
                slot  <= slot_nxt;
                lrclk <= slot_nxt[SLOT_W-1];
                sdata <= shreg[FRAME_BITS-1];
                if (slot_nxt == '0) begin
                    shreg <= enable ? {in, in} : '0;
                end else begin
                    shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule
